// File: rtl/bf_out_collector.sv
// Output stage behind the radix-2 NTT butterfly PE: tracks issued butterflies through the
// fixed PE latency, buffers result pairs and serialises them onto a valid/ready stream.
module bf_out_collector #(
  parameter int unsigned data_width = 12,
  parameter int unsigned PE_LAT     = 6,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned N_COEF     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_in_fire,
  output logic                  issue_ok,
  input  logic [data_width-1:0] bf_lower,
  input  logic [data_width-1:0] bf_upper,
  output logic [data_width-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  ovf_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW = $clog2(DEPTH + 1);
  localparam int unsigned CW = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  localparam logic S_LO = 1'b0;
  localparam logic S_HI = 1'b1;

  localparam logic [RW-1:0] RES_FULL  = RW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_COEF - 1);

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_empty;

  logic [PE_LAT-1:0]     r_dly;
  logic [RW-1:0]         r_reserved;
  logic [RW-1:0]         w_reserved_d;
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_rd_idx;
  logic [data_width-1:0] r_mem_lo [DEPTH];
  logic [data_width-1:0] r_mem_hi [DEPTH];
  logic                  r_state;
  logic                  w_state_d;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_d;
  logic                  r_ovf;

  // Credit is a pure function of registered state so upstream never sees a same-cycle drain.
  assign issue_ok  = (r_reserved < RES_FULL);
  assign w_accept  = pe_in_fire & issue_ok;
  assign w_capture = r_dly[PE_LAT-1];

  // Delay line: bit k set means an accepted butterfly is k+1 cycles into the PE.
  generate
    if (PE_LAT == 1) begin : g_dly_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dly <= '0;
        end else begin
          r_dly <= w_accept;
        end
      end
    end else begin : g_dly_shift
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dly <= '0;
        end else begin
          r_dly <= {r_dly[PE_LAT-2:0], w_accept};
        end
      end
    end
  endgenerate

  // Pair FIFO with wrap-bit pointers; credit guarantees a capture never meets a full FIFO.
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_lo[w_wr_idx] <= bf_lower;
      r_mem_hi[w_wr_idx] <= bf_upper;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Serialiser: lower word first, upper word pops the head pair.
  assign dout_valid = ~w_empty;
  assign w_hs       = dout_valid & dout_ready;
  assign w_pop      = w_hs & (r_state == S_HI);

  always_comb begin
    dout = '0;
    if (dout_valid) begin
      dout = (r_state == S_HI) ? r_mem_hi[w_rd_idx] : r_mem_lo[w_rd_idx];
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (w_hs) begin
      w_state_d = (r_state == S_LO) ? S_HI : S_LO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LO;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Reserved = in-flight + stored pairs.
  always_comb begin
    w_reserved_d = r_reserved;
    unique case ({w_accept, w_pop})
      2'b10:   w_reserved_d = r_reserved + RW'(1);
      2'b01:   w_reserved_d = r_reserved - RW'(1);
      default: w_reserved_d = r_reserved;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reserved <= '0;
    end else begin
      r_reserved <= w_reserved_d;
    end
  end

  // Coefficient position within the transform.
  always_comb begin
    w_count_d = r_count;
    if (w_hs) begin
      w_count_d = (r_count == CNT_LAST) ? '0 : r_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign dout_last = dout_valid & (r_count == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (pe_in_fire && !issue_ok) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_err = r_ovf;

endmodule

// File: tb/tb_bf_out_collector.sv
// Directed bench for bf_out_collector: a behavioural PE feeds result pairs after PE_LAT
// cycles and a scoreboard checks the serial stream, credit, overflow and last flags.
module tb_bf_out_collector;

  localparam int unsigned DW     = 12;
  localparam int unsigned PE_LAT = 6;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned N_COEF = 8;

  logic          clk;
  logic          rst;
  logic          pe_in_fire;
  logic          issue_ok;
  logic [DW-1:0] bf_lower;
  logic [DW-1:0] bf_upper;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          ovf_err;

  bf_out_collector #(
    .data_width (DW),
    .PE_LAT     (PE_LAT),
    .DEPTH      (DEPTH),
    .N_COEF     (N_COEF)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pe_in_fire (pe_in_fire),
    .issue_ok   (issue_ok),
    .bf_lower   (bf_lower),
    .bf_upper   (bf_upper),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural PE and scoreboard state
  logic [DW-1:0] fire_lo;
  logic [DW-1:0] fire_hi;
  logic          sr_v  [1:PE_LAT];
  logic [DW-1:0] sr_lo [1:PE_LAT];
  logic [DW-1:0] sr_hi [1:PE_LAT];
  logic [DW-1:0] exp_q [$];
  int            hs_cnt    = 0;
  int            words_out = 0;
  int            last_cnt  = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout  = '0;
  logic          prev_last  = 1'b0;

  initial begin
    for (int i = 1; i <= int'(PE_LAT); i++) begin
      sr_v[i]  = 1'b0;
      sr_lo[i] = '0;
      sr_hi[i] = '0;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      for (int i = 1; i <= int'(PE_LAT); i++) sr_v[i] = 1'b0;
      exp_q.delete();
      hs_cnt     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(dout_valid), 32'd1);
        check("hold_dout", 32'(dout), 32'(prev_dout));
        check("hold_last", 32'(dout_last), 32'(prev_last));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(dout_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(dout), 32'(e));
        end
        check("last_flag", 32'(dout_last), 32'((hs_cnt % int'(N_COEF)) == int'(N_COEF) - 1));
        hs_cnt++;
        words_out++;
        if (dout_last) last_cnt++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      for (int i = int'(PE_LAT); i >= 2; i--) begin
        sr_v[i]  = sr_v[i-1];
        sr_lo[i] = sr_lo[i-1];
        sr_hi[i] = sr_hi[i-1];
      end
      sr_v[1]  = pe_in_fire && issue_ok;
      sr_lo[1] = fire_lo;
      sr_hi[1] = fire_hi;
      if (pe_in_fire && issue_ok) begin
        exp_q.push_back(fire_lo);
        exp_q.push_back(fire_hi);
      end
    end
  end

  // PE output bus: result of the fire PE_LAT cycles back, junk otherwise.
  always @(posedge clk) begin
    #1;
    if (sr_v[PE_LAT]) begin
      bf_lower = sr_lo[PE_LAT];
      bf_upper = sr_hi[PE_LAT];
    end else begin
      bf_lower = DW'($urandom);
      bf_upper = DW'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst        = 1'b0;
    pe_in_fire = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int sent;
    int guard;
    int vcnt;
    rst        = 1'b0;
    pe_in_fire = 1'b0;
    dout_ready = 1'b0;
    fire_lo    = '0;
    fire_hi    = '0;
    bf_lower   = '0;
    bf_upper   = '0;

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_issue_ok", 32'(issue_ok), 32'd1);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(dout_valid), 32'd0);

    // Single pair: fire in cycle 0, words in cycles 7 and 8
    step();
    pe_in_fire = 1'b1;
    fire_lo    = 12'h123;
    fire_hi    = 12'h456;
    dout_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      pe_in_fire = 1'b0;
      @(negedge clk);
      if (c == 6) check("single_c6_valid", 32'(dout_valid), 32'd0);
      if (c == 7) begin
        check("single_c7_valid", 32'(dout_valid), 32'd1);
        check("single_c7_dout", 32'(dout), 32'h123);
      end
      if (c == 8) begin
        check("single_c8_valid", 32'(dout_valid), 32'd1);
        check("single_c8_dout", 32'(dout), 32'h456);
      end
      if (c == 9) check("single_c9_valid", 32'(dout_valid), 32'd0);
    end

    // Backpressure fill, then overflow pulse, then drain
    reset_dut();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 7) check("credit_c7", 32'(issue_ok), 32'd1);
      if (i == 8) check("credit_c8", 32'(issue_ok), 32'd0);
      pe_in_fire = issue_ok;
      fire_lo    = DW'(12'h200 + i);
      fire_hi    = DW'(12'hA00 + i);
      if (issue_ok) acc++;
    end
    step();
    pe_in_fire = 1'b0;
    check("fill_accepted", 32'(acc), 32'd8);
    repeat (8) step();
    @(negedge clk);
    check("fill_head_valid", 32'(dout_valid), 32'd1);
    check("fill_head_dout", 32'(dout), 32'h200);
    check("fill_no_ovf", 32'(ovf_err), 32'd0);
    step();
    pe_in_fire = 1'b1;
    fire_lo    = 12'hEEE;
    fire_hi    = 12'hFFF;
    step();
    pe_in_fire = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(ovf_err), 32'd1);
    words_out = 0;
    step();
    dout_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || dout_valid) && guard < 60) begin
      step();
      guard++;
    end
    @(negedge clk);
    check("drain_words", 32'(words_out), 32'd16);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(dout_valid), 32'd0);
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    check("drain_issue_ok", 32'(issue_ok), 32'd1);

    // Last flag and counter wrap with random backpressure
    reset_dut();
    check("ovf_cleared", 32'(ovf_err), 32'd0);
    words_out = 0;
    last_cnt  = 0;
    sent      = 0;
    guard     = 0;
    while ((sent < 8 || words_out < 16) && guard < 400) begin
      step();
      guard++;
      dout_ready = 1'($urandom_range(0, 1));
      if (sent < 8 && issue_ok) begin
        pe_in_fire = 1'b1;
        fire_lo    = DW'(12'h300 + sent);
        fire_hi    = DW'(12'hB00 + sent);
        sent++;
      end else begin
        pe_in_fire = 1'b0;
      end
    end
    pe_in_fire = 1'b0;
    check("wrap_words", 32'(words_out), 32'd16);
    check("wrap_lasts", 32'(last_cnt), 32'd2);

    // Reset with 2 pairs buffered and 3 in flight
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      step();
      pe_in_fire = 1'b1;
      fire_lo    = DW'(12'h400 + i);
      fire_hi    = DW'(12'hC00 + i);
    end
    step();
    pe_in_fire = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("midop_valid_before", 32'(dout_valid), 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("midop_valid_rst", 32'(dout_valid), 32'd0);
    check("midop_issue_ok", 32'(issue_ok), 32'd1);
    check("midop_dout", 32'(dout), 32'd0);
    repeat (2) step();
    rst        = 1'b1;
    dout_ready = 1'b1;
    words_out  = 0;
    vcnt       = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      if (dout_valid) vcnt++;
    end
    check("midop_no_valid", 32'(vcnt), 32'd0);
    check("midop_no_words", 32'(words_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
